obj_row_scanout: RTL and testbench
==================================

// Module: obj_row_scanout
// PURPOSE
//  Read-side sequencer for the OBJ row double buffer. The sprite renderer writes line N+1 into one
//  half while this block drains line N from the other half.
//  On each line_start it walks rcol 0..NUM_COLS-1 at pixel cadence and presents decoded OBJ pixels
//  to the compositor over a valid/ready link. Then it clears the drained half for reuse.
//  Owns the buffer row select; sits between the OBJ row buffer and the layer compositor.
// PARAMETERS
//  NUM_COLS    240  visible columns per line; rcol >= NUM_COLS never issued
//  LINES       228  lines per frame; buf_row wraps at LINES
//  PIX_CYCLES  4    min clocks between successive column fetches (>=2)
// PORTS
//  clock        in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  line_start   in   1   1-cycle pulse: begin scanout of line vcount
//  vcount       in   8   displayed line number, sampled on accepted line_start
//  buf_row      out  8   row select to double buffer (bit0 picks halves)
//  rcol         out  8   read column to double buffer
//  rdata        in   20  buffer entry for rcol, combinational from rcol/buf_row
//  buf_clear    out  1   whole-half clear strobe to double buffer
//  wr_block     out  1   renderer must not assert we this cycle
//  pix_valid    out  1   pixel on pix_* is valid
//  pix_ready    in   1   compositor accepts pixel
//  pix_col      out  8   column of presented pixel
//  pix_color    out  15  rdata[14:0], BGR555
//  pix_attr     out  4   rdata[19:16]
//  pix_transp   out  1   1 when rdata[15:0]==0 (cleared/empty entry)
//  busy         out  1   state != IDLE
//  line_done    out  1   1-cycle pulse, last pixel accepted and clear issued
//  overrun      out  1   1-cycle pulse, line_start arrived while busy
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; every output 0; internal line, rcol, and pace counter 0.
//  Reset mid-line abandons the line; no clear is issued.
//  Row select:
//  - Outside CLEAR: buf_row = (line==LINES-1) ? 0 : line+1.
//  - With that value, reads come from the half holding `line`.
//  - In CLEAR: buf_row = line, which flips bit0 so the clear hits the half just read.
//  FSM IDLE -> FETCH -> PRESENT -> (FETCH | CLEAR) -> IDLE:
//  - IDLE: on line_start, latch line=vcount, set rcol=0, pace=0, go FETCH.
//  - FETCH (1 cycle): register pix_col=rcol, pix_color, pix_attr, pix_transp from rdata; go PRESENT.
//    rcol is stable through FETCH.
//  - PRESENT:
//    - pace increments each cycle, saturating at PIX_CYCLES-1.
//    - pace counts from FETCH entry, so the fetch-to-fetch interval is >= PIX_CYCLES.
//    - pix_valid = (pace==PIX_CYCLES-1).
//    - Handshake = pix_valid & pix_ready. Pix_* are held stable while valid and not ready.
//    - On handshake with rcol<NUM_COLS-1: rcol+1, pace=0, go FETCH.
//    - On handshake with rcol==NUM_COLS-1: go CLEAR.
//  - CLEAR (1 cycle): buf_clear=1, wr_block=1, line_done=1, pix_valid=0; go IDLE.
//  Outputs that are 0 when not driven by their state:
//  - buf_clear, wr_block, line_done, overrun are registered pulses.
//  - pix_valid is 0 outside PRESENT.
//  line_start outside IDLE (FETCH/PRESENT/CLEAR): ignored; overrun pulses the next cycle.
//  line_start in IDLE on the cycle after CLEAR is accepted normally.
//  vcount >= LINES is accepted unchanged. buf_row is then vcount+1, with no wrap check.
//  Nominal line = NUM_COLS*PIX_CYCLES + 1 clocks with ready held high.
//  A stalled pix_ready stretches the line without limit.
// STRUCTURE
//  Package obj_pkg:
//  - typedef obj_entry_t: packed struct {attr[3:0], rsvd, color[14:0]}, 20 bits, for the rdata decode.
//  - typedef scan_state_t {IDLE, FETCH, PRESENT, CLEAR}.
//  - localparams OBJ_COLS=240 and OBJ_LINES=228.
//  Single module; no sub-modules. The pace counter and rcol counter are inline.
// TESTING
//  1. Reset: hold reset=0 -> all outputs 0. Release with no line_start -> busy stays 0.
//  2. Full line, vcount=5, pix_ready=1, PIX_CYCLES=4 -> buf_row=6 during scan.
//     pix_valid every 4 clocks; 240 pixels with pix_col 0..239.
//     CLEAR cycle: buf_row=5, buf_clear=1, line_done=1; 961 clocks line_start->line_done.
//  3. rdata model entry col 7 = 20'hA_1234 -> pix_col=7, pix_attr=4'hA, pix_color=15'h1234, pix_transp=0.
//     Col 8 = 0 -> pix_transp=1.
//  4. pix_ready low 10 cycles at col 100 -> pix_* stable and valid throughout.
//     rcol stays 100; no skipped or duplicated column.
//  5. vcount=227 -> buf_row=0 during scan, buf_row=227 in CLEAR.
//     line_start at col 50 -> overrun 1 pulse, scan continues to 239.
//  6. reset=0 at col 120 -> immediate IDLE, no buf_clear.
//     Next line_start, vcount=9 -> clean scan from col 0.

Source files
------------

// File: rtl/obj_pkg.sv
// Shared types for the OBJ row scanout: row-buffer entry layout, scan FSM states and
// the default geometry of the visible line.
package obj_pkg;

    localparam int OBJ_COLS  = 240;
    localparam int OBJ_LINES = 228;

    // One row-buffer entry; {rsvd, color} all-zero marks a cleared (transparent) slot.
    typedef struct packed {
        logic [3:0]  attr;
        logic        rsvd;
        logic [14:0] color;
    } obj_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        CLEAR   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/obj_row_scanout_if.sv
// Pixel link from the OBJ row scanout to the layer compositor.
interface obj_row_scanout_if;

    // A pixel moves when pix_valid & pix_ready are both high at a rising clock edge;
    // once pix_valid is raised, it and every pix_* field hold until that edge.
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_col;
    logic [14:0] pix_color;
    logic [3:0]  pix_attr;
    logic        pix_transp;

    modport master (
        output pix_valid, pix_col, pix_color, pix_attr, pix_transp,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_col, pix_color, pix_attr, pix_transp,
        output pix_ready
    );

endinterface

// File: rtl/obj_row_scanout.sv
// Drains one line of the OBJ row double buffer to the compositor at pixel cadence,
// then clears the drained half so the renderer can refill it.
module obj_row_scanout
  import obj_pkg::*;
#(
  parameter int NUM_COLS   = OBJ_COLS,
  parameter int LINES      = OBJ_LINES,
  parameter int PIX_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              line_start,
  input  logic [7:0]        vcount,
  output logic [7:0]        buf_row,
  output logic [7:0]        rcol,
  input  logic [19:0]       rdata,
  output logic              buf_clear,
  output logic              wr_block,
  output logic              busy,
  output logic              line_done,
  output logic              overrun,
  output scan_state_t       dbg_state,
  obj_row_scanout_if.master pix
);

  localparam int             PW        = $clog2(PIX_CYCLES);
  localparam logic [PW-1:0]  PACE_MAX  = PW'(PIX_CYCLES - 1);
  localparam logic [7:0]     LAST_COL  = 8'(NUM_COLS - 1);
  localparam logic [7:0]     LAST_LINE = 8'(LINES - 1);

  scan_state_t   state_q;
  logic [7:0]    line_q;
  logic [7:0]    rcol_q;
  logic [PW-1:0] pace_q;
  logic [PW-1:0] pace_d;
  logic [7:0]    buf_row_q;
  logic [7:0]    pix_col_q;
  logic [14:0]   pix_color_q;
  logic [3:0]    pix_attr_q;
  logic          pix_transp_q;
  logic          clear_q;
  logic          overrun_q;
  logic          handshake;
  obj_entry_t    entry;

  // The renderer fills line+1 into the half not being read; only the last line wraps.
  function automatic logic [7:0] read_row(input logic [7:0] l);
    return (l == LAST_LINE) ? 8'd0 : l + 8'd1;
  endfunction

  assign entry     = rdata;
  assign pace_d    = (pace_q == PACE_MAX) ? pace_q : pace_q + PW'(1);
  assign handshake = pix.pix_valid & pix.pix_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      line_q       <= '0;
      rcol_q       <= '0;
      pace_q       <= '0;
      buf_row_q    <= '0;
      pix_col_q    <= '0;
      pix_color_q  <= '0;
      pix_attr_q   <= '0;
      pix_transp_q <= 1'b0;
      clear_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= line_start && (state_q != IDLE);
      clear_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (line_start) begin
            line_q    <= vcount;
            rcol_q    <= '0;
            pace_q    <= '0;
            buf_row_q <= read_row(vcount);
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          pix_col_q    <= rcol_q;
          pix_color_q  <= entry.color;
          pix_attr_q   <= entry.attr;
          pix_transp_q <= ({entry.rsvd, entry.color} == 16'd0);
          pace_q       <= pace_d;
          state_q      <= PRESENT;
        end
        PRESENT: begin
          if (handshake && (rcol_q == LAST_COL)) begin
            // Pointing buf_row back at the current line flips bit0 onto the half just drained.
            buf_row_q <= line_q;
            clear_q   <= 1'b1;
            state_q   <= CLEAR;
          end else if (handshake) begin
            rcol_q  <= rcol_q + 8'd1;
            pace_q  <= '0;
            state_q <= FETCH;
          end else begin
            pace_q <= pace_d;
          end
        end
        CLEAR: begin
          buf_row_q <= read_row(line_q);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign buf_row        = buf_row_q;
  assign rcol           = rcol_q;
  assign buf_clear      = clear_q;
  assign wr_block       = clear_q;
  assign line_done      = clear_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state      = state_q;

  assign pix.pix_valid  = (state_q == PRESENT) && (pace_q == PACE_MAX);
  assign pix.pix_col    = pix_col_q;
  assign pix.pix_color  = pix_color_q;
  assign pix.pix_attr   = pix_attr_q;
  assign pix.pix_transp = pix_transp_q;

endmodule

// File: tb/tb_obj_row_scanout.sv
// Randomized bench for obj_row_scanout: a line-level model predicts every output each
// cycle, plus directed scenarios with hand-computed expectations.
module tb_obj_row_scanout;
  import obj_pkg::*;

  localparam int NUM_COLS   = 240;
  localparam int LINES      = 228;
  localparam int PIX_CYCLES = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  vcount = 8'd0;
  logic [7:0]  buf_row;
  logic [7:0]  rcol;
  logic [19:0] rdata;
  logic        buf_clear;
  logic        wr_block;
  logic        busy;
  logic        line_done;
  logic        overrun;
  scan_state_t dbg_state;
  logic [31:0] salt = 32'd0;

  obj_row_scanout_if pix_if ();

  obj_row_scanout dut (
    .clock      (clock),
    .reset      (reset),
    .line_start (line_start),
    .vcount     (vcount),
    .buf_row    (buf_row),
    .rcol       (rcol),
    .rdata      (rdata),
    .buf_clear  (buf_clear),
    .wr_block   (wr_block),
    .busy       (busy),
    .line_done  (line_done),
    .overrun    (overrun),
    .dbg_state  (dbg_state),
    .pix        (pix_if.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- row buffer contents ----------------
  function automatic logic [19:0] gen(input logic [7:0] row, input logic [7:0] col,
                                      input logic [31:0] s);
    logic [31:0] h;
    if (col == 8'd7) return 20'hA1234;
    if (col == 8'd8) return 20'h00000;
    h = (32'(col) * 32'd2654435761) ^ (32'(row) * 32'd40503) ^ s;
    if (h[31:28] == 4'd0) return {h[3:0], 16'h0000};
    return h[19:0];
  endfunction

  assign rdata = gen(buf_row, rcol, salt);

  function automatic logic [7:0] row_after(input logic [7:0] v);
    return (32'(v) == LINES - 1) ? 8'd0 : v + 8'd1;
  endfunction

  // ---------------- driver tasks ----------------
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       pix_if.pix_ready = 1'b1;
      1:       pix_if.pix_ready = ($urandom_range(0, 3) != 0);
      default: pix_if.pix_ready = 1'b0;
    endcase
  end

  task automatic pulse_line(input logic [7:0] v);
    @(posedge clock); #1;
    line_start = 1'b1;
    vcount     = v;
    @(posedge clock); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_col(input int col, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (pix_if.pix_valid && (32'(pix_if.pix_col) == col)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (line_done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // ---------------- scoreboard / line model ----------------
  logic [27:0] exp_q[$];  // {col, entry} still owed to the compositor
  bit          m_busy = 1'b0;
  bit          m_in_clear = 1'b0;
  bit          m_overrun = 1'b0;
  logic [7:0]  m_line = 8'd0;
  int          m_cnt = 0;
  int          cyc = 0;
  int          m_accept_cyc = 0;
  int          last_clocks = 0;
  int          hs_count = 0;
  int          ovr_count = 0;

  always @(negedge clock) begin
    bit          exp_valid;
    bit          hs;
    bit          old_busy;
    logic [27:0] front;
    logic [27:0] act_pix;
    logic [27:0] exp_pix;
    cyc++;
    if (!reset) begin
      chk_eq("reset_outputs",
             32'({busy, buf_clear, wr_block, line_done, overrun, pix_if.pix_valid,
                  buf_row, rcol, pix_if.pix_transp}), 32'd0);
      chk_eq("reset_pix_fields", 32'({pix_if.pix_col, pix_if.pix_attr, pix_if.pix_color}), 32'd0);
      exp_q.delete();
      m_busy = 1'b0;
      m_in_clear = 1'b0;
      m_overrun = 1'b0;
      m_cnt = 0;
    end else begin
      if (m_cnt > 0) m_cnt--;
      exp_valid = m_busy && !m_in_clear && (m_cnt == 0) && (exp_q.size() > 0);
      chk_eq("busy", 32'(busy), 32'(m_busy));
      chk_eq("buf_clear", 32'(buf_clear), 32'(m_in_clear));
      chk_eq("wr_block", 32'(wr_block), 32'(m_in_clear));
      chk_eq("line_done", 32'(line_done), 32'(m_in_clear));
      chk_eq("overrun", 32'(overrun), 32'(m_overrun));
      chk_eq("pix_valid", 32'(pix_if.pix_valid), 32'(exp_valid));
      if (m_busy) chk_eq("buf_row", 32'(buf_row), 32'(m_in_clear ? m_line : row_after(m_line)));
      if (overrun) ovr_count++;
      if (pix_if.pix_valid && (exp_q.size() > 0)) begin
        front   = exp_q[0];
        exp_pix = {front[27:20], front[19:16], front[14:0], (front[15:0] == 16'd0)};
        act_pix = {pix_if.pix_col, pix_if.pix_attr, pix_if.pix_color, pix_if.pix_transp};
        chk_eq("pixel", 32'(act_pix), 32'(exp_pix));
      end
      hs = exp_valid && pix_if.pix_valid && pix_if.pix_ready;

      old_busy  = m_busy;
      m_overrun = line_start && old_busy;
      if (m_in_clear) begin
        m_in_clear  = 1'b0;
        m_busy      = 1'b0;
        last_clocks = cyc - m_accept_cyc;
      end else if (hs) begin
        void'(exp_q.pop_front());
        hs_count++;
        if (exp_q.size() == 0) m_in_clear = 1'b1;
        else m_cnt = PIX_CYCLES;
      end
      if (!old_busy && line_start) begin
        m_busy       = 1'b1;
        m_line       = vcount;
        m_cnt        = PIX_CYCLES;
        m_accept_cyc = cyc;
        hs_count     = 0;
        exp_q.delete();
        for (int c = 0; c < NUM_COLS; c++)
          exp_q.push_back({8'(c), gen(row_after(vcount), 8'(c), salt)});
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    bit ok;
    int ovr_base;
    int extra;
    logic [7:0] v;
    salt = $urandom;
    pix_if.pix_ready = 1'b1;

    // Reset held, then released with nothing to do.
    repeat (3) @(negedge clock);
    chk_eq("reset_busy", 32'(busy), 32'd0);
    @(posedge clock); #1 reset = 1'b1;
    repeat (5) @(negedge clock);
    chk_eq("idle_busy", 32'(busy), 32'd0);
    chk_eq("idle_buf_row", 32'(buf_row), 32'd0);

    // Full line at vcount 5 with ready held high.
    pulse_line(8'd5);
    wait_col(7, 200, ok);
    chk_eq("wait_col7", 32'(ok), 32'd1);
    chk_eq("col7_attr", 32'(pix_if.pix_attr), 32'hA);
    chk_eq("col7_color", 32'(pix_if.pix_color), 32'h1234);
    chk_eq("col7_transp", 32'(pix_if.pix_transp), 32'd0);
    wait_col(8, 200, ok);
    chk_eq("wait_col8", 32'(ok), 32'd1);
    chk_eq("col8_transp", 32'(pix_if.pix_transp), 32'd1);
    wait_col(10, 200, ok);
    chk_eq("scan_buf_row_v5", 32'(buf_row), 32'd6);
    wait_done(2000, ok);
    chk_eq("done_v5", 32'(ok), 32'd1);
    chk_eq("clear_buf_row_v5", 32'(buf_row), 32'd5);
    chk_eq("clear_strobe_v5", 32'(buf_clear), 32'd1);
    @(negedge clock);
    chk_eq("line_clocks", 32'(last_clocks), 32'd961);
    chk_eq("pixels_v5", 32'(hs_count), 32'd240);

    // Stall the compositor for 10 cycles with column 100 on the link.
    pulse_line(8'd40);
    wait_col(99, 1000, ok);
    chk_eq("wait_col99", 32'(ok), 32'd1);
    @(posedge clock);
    ready_mode = 2;
    wait_col(100, 50, ok);
    chk_eq("wait_col100", 32'(ok), 32'd1);
    repeat (10) begin
      @(negedge clock);
      chk_eq("stall_hold", 32'({pix_if.pix_valid, pix_if.pix_col, rcol}), {15'd0, 1'b1, 8'd100, 8'd100});
    end
    @(posedge clock);
    ready_mode = 0;
    wait_done(2000, ok);
    chk_eq("done_stall", 32'(ok), 32'd1);
    @(negedge clock);
    chk_eq("pixels_stall", 32'(hs_count), 32'd240);

    // Last line of the frame, with an overlapping line_start at column 50.
    ovr_base = ovr_count;
    pulse_line(8'd227);
    wait_col(20, 200, ok);
    chk_eq("scan_buf_row_v227", 32'(buf_row), 32'd0);
    wait_col(50, 400, ok);
    chk_eq("wait_col50", 32'(ok), 32'd1);
    pulse_line(8'd33);
    wait_done(2000, ok);
    chk_eq("done_v227", 32'(ok), 32'd1);
    chk_eq("clear_buf_row_v227", 32'(buf_row), 32'd227);
    @(negedge clock);
    chk_eq("overrun_pulses", 32'(ovr_count - ovr_base), 32'd1);
    chk_eq("pixels_v227", 32'(hs_count), 32'd240);

    // Reset in the middle of a line abandons it without a clear.
    pulse_line(8'd60);
    wait_col(120, 1000, ok);
    chk_eq("wait_col120", 32'(ok), 32'd1);
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk_eq("post_reset_quiet", 32'({busy, buf_clear}), 32'd0);
    end
    pulse_line(8'd9);
    wait_col(0, 20, ok);
    chk_eq("restart_col0", 32'(ok), 32'd1);
    chk_eq("restart_buf_row", 32'(buf_row), 32'd10);
    wait_done(2000, ok);
    chk_eq("done_v9", 32'(ok), 32'd1);
    @(negedge clock);
    chk_eq("pixels_v9", 32'(hs_count), 32'd240);

    // Random lines with random back-pressure and stray line_starts.
    ready_mode = 1;
    for (int n = 0; n < 6; n++) begin
      case (n)
        2:       v = 8'd250;
        4:       v = 8'd255;
        5:       v = 8'd227;
        default: v = 8'($urandom_range(0, LINES - 1));
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clock);
      pulse_line(v);
      if ($urandom_range(0, 1) == 1) begin
        extra = $urandom_range(10, 400);
        repeat (extra) @(posedge clock);
        pulse_line(8'($urandom));
      end
      wait_done(6000, ok);
      chk_eq("done_random", 32'(ok), 32'd1);
      @(negedge clock);
      chk_eq("pixels_random", 32'(hs_count), 32'd240);
    end
    ready_mode = 0;
    repeat (4) @(negedge clock);
    chk_eq("final_idle", 32'({busy, buf_clear, pix_if.pix_valid}), 32'd0);
    chk_eq("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
